// File: rtl/hvac_controller.sv
// rtl/hvac_controller.sv - heater/cooler sequencer with hysteresis, minimum run time and lockout
module hvac_controller #(
   parameter int LOW_T   = 50,
   parameter int HIGH_T  = 80,
   parameter int HYST    = 2,
   parameter int MIN_ON  = 8,
   parameter int LOCKOUT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] st,
   input  logic       sw,
   input  logic       sfa,
   input  logic       en,
   output logic       heater,
   output logic       cooler,
   output logic [1:0] hvac_state
);

   // Counter only needs to reach the larger of the two dwell limits.
   localparam int CNT_MAX_I = (MIN_ON > LOCKOUT) ? MIN_ON : LOCKOUT;
   localparam int CW        = $clog2(CNT_MAX_I + 1);

   localparam logic [CW-1:0] CNT_MAX    = CW'(CNT_MAX_I);
   localparam logic [CW-1:0] MIN_ON_M1  = CW'(MIN_ON - 1);
   localparam logic [CW-1:0] LOCKOUT_M1 = CW'(LOCKOUT - 1);

   // Thresholds widened to 8 bits so LOW_T + HYST cannot wrap.
   localparam logic [7:0] LOW_TH    = 8'(LOW_T);
   localparam logic [7:0] HIGH_TH   = 8'(HIGH_T);
   localparam logic [7:0] HEAT_EXIT = 8'(LOW_T + HYST);
   localparam logic [7:0] COOL_EXIT = 8'(HIGH_T - HYST);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_HEAT = 2'b01,
      S_COOL = 2'b10,
      S_LOCK = 2'b11
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          heater_q, heater_d;
   logic          cooler_q, cooler_d;

   logic       inh;
   logic [7:0] st_w;

   assign inh  = sw | sfa | ~en;
   assign st_w = {1'b0, st};

   // Next-state, dwell counter and registered actuator decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (!inh) begin
               if (st_w < LOW_TH)       state_d = S_HEAT;
               else if (st_w > HIGH_TH) state_d = S_COOL;
            end
         end
         S_HEAT: begin
            if (inh)                                           state_d = S_LOCK;
            else if (cnt_q >= MIN_ON_M1 && st_w >= HEAT_EXIT)  state_d = S_LOCK;
         end
         S_COOL: begin
            if (inh)                                           state_d = S_LOCK;
            else if (cnt_q >= MIN_ON_M1 && st_w <= COOL_EXIT)  state_d = S_LOCK;
         end
         default: begin
            // Lockout always runs to completion; inhibit and temperature are ignored.
            if (cnt_q == LOCKOUT_M1) state_d = S_IDLE;
         end
      endcase

      cnt_d = cnt_q;
      if (state_d != state_q)
         cnt_d = '0;
      else if (state_q != S_IDLE && cnt_q != CNT_MAX)
         cnt_d = cnt_q + 1'b1;

      heater_d = (state_d == S_HEAT);
      cooler_d = (state_d == S_COOL);
   end

   // State register; reset returns to IDLE without passing through lockout.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         heater_q <= 1'b0;
         cooler_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         heater_q <= heater_d;
         cooler_q <= cooler_d;
      end
   end

   assign heater     = heater_q;
   assign cooler     = cooler_q;
   assign hvac_state = state_q;

endmodule

// File: tb/tb_hvac_controller.sv
// tb/tb_hvac_controller.sv - directed self-checking bench for hvac_controller
module tb_hvac_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] st  = 7'd60;
   logic       sw  = 1'b0;
   logic       sfa = 1'b0;
   logic       en  = 1'b1;
   logic       heater;
   logic       cooler;
   logic [1:0] hvac_state;

   int vectors    = 0;
   int miscompares = 0;

   hvac_controller dut (
      .clk        (clk),
      .rst        (rst),
      .st         (st),
      .sw         (sw),
      .sfa        (sfa),
      .en         (en),
      .heater     (heater),
      .cooler     (cooler),
      .hvac_state (hvac_state)
   );

   always #5 clk = ~clk;

   // One rising edge, then settle before anything is sampled or driven.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [1:0] exp_s;
      rst = 1'b1; st = 7'd60; sw = 1'b0; sfa = 1'b0; en = 1'b1;
      step();
      step();
      exp_s = 2'b00;
      if (hvac_state !== exp_s || heater !== 1'b0 || cooler !== 1'b0) begin
         $display("FAIL reset: got state=%b heater=%b cooler=%b, want state=%b heater=0 cooler=0",
                  hvac_state, heater, cooler, exp_s);
         miscompares++;
      end
      vectors++;
      rst = 1'b0;
   endtask

   task automatic test_heat_min_run();
      logic [1:0] exp_s;
      st = 7'd40;
      step();
      st = 7'd60;
      for (int i = 0; i < 14; i++) begin
         exp_s = (i < 8) ? 2'b01 : (i < 12) ? 2'b11 : 2'b00;
         if (hvac_state !== exp_s || heater !== (exp_s == 2'b01) || cooler !== 1'b0) begin
            $display("FAIL heat_min_run cycle %0d: got state=%b heater=%b cooler=%b, want state=%b",
                     i, hvac_state, heater, cooler, exp_s);
            miscompares++;
         end
         vectors++;
         step();
      end
   endtask

   task automatic test_heat_hysteresis();
      logic [1:0] exp_s;
      st = 7'd40;
      step();
      st = 7'd51;
      for (int i = 0; i < 10; i++) begin
         exp_s = 2'b01;
         if (hvac_state !== exp_s || heater !== 1'b1) begin
            $display("FAIL heat_hyst_hold cycle %0d: got state=%b heater=%b, want state=%b heater=1",
                     i, hvac_state, heater, exp_s);
            miscompares++;
         end
         vectors++;
         step();
      end
      st = 7'd52;
      step();
      st = 7'd60;
      exp_s = 2'b11;
      if (hvac_state !== exp_s || heater !== 1'b0) begin
         $display("FAIL heat_hyst_exit: got state=%b heater=%b, want state=%b heater=0",
                  hvac_state, heater, exp_s);
         miscompares++;
      end
      vectors++;
      for (int i = 0; i < 4; i++) step();
      exp_s = 2'b00;
      if (hvac_state !== exp_s) begin
         $display("FAIL heat_hyst_idle: got state=%b, want state=%b", hvac_state, exp_s);
         miscompares++;
      end
      vectors++;
   endtask

   task automatic test_cool_hysteresis();
      logic [1:0] exp_s;
      st = 7'd90;
      for (int i = 0; i < 8; i++) begin
         step();
         exp_s = 2'b10;
         if (hvac_state !== exp_s || cooler !== 1'b1 || heater !== 1'b0) begin
            $display("FAIL cool_on cycle %0d: got state=%b cooler=%b heater=%b, want state=%b cooler=1",
                     i, hvac_state, cooler, heater, exp_s);
            miscompares++;
         end
         vectors++;
      end
      st = 7'd79;
      for (int i = 0; i < 3; i++) begin
         step();
         exp_s = 2'b10;
         if (hvac_state !== exp_s || cooler !== 1'b1) begin
            $display("FAIL cool_hyst_hold cycle %0d: got state=%b cooler=%b, want state=%b cooler=1",
                     i, hvac_state, cooler, exp_s);
            miscompares++;
         end
         vectors++;
      end
      st = 7'd78;
      step();
      st = 7'd60;
      exp_s = 2'b11;
      if (hvac_state !== exp_s || cooler !== 1'b0) begin
         $display("FAIL cool_hyst_exit: got state=%b cooler=%b, want state=%b cooler=0",
                  hvac_state, cooler, exp_s);
         miscompares++;
      end
      vectors++;
      for (int i = 0; i < 4; i++) step();
   endtask

   // kind: 0 = window open, 1 = fire alarm, 2 = enable low
   task automatic test_inhibit(input int kind);
      logic [1:0] exp_s;
      rst = 1'b1; step(); rst = 1'b0;
      st = 7'd40;
      for (int i = 0; i < 3; i++) step();
      exp_s = 2'b01;
      if (hvac_state !== exp_s || heater !== 1'b1) begin
         $display("FAIL inhibit%0d_pre: got state=%b heater=%b, want state=%b heater=1",
                  kind, hvac_state, heater, exp_s);
         miscompares++;
      end
      vectors++;
      sw  = (kind == 0);
      sfa = (kind == 1);
      en  = (kind != 2);
      for (int i = 0; i < 8; i++) begin
         step();
         exp_s = (i < 4) ? 2'b11 : 2'b00;
         if (hvac_state !== exp_s || heater !== 1'b0 || cooler !== 1'b0) begin
            $display("FAIL inhibit%0d cycle %0d: got state=%b heater=%b cooler=%b, want state=%b heater=0",
                     kind, i, hvac_state, heater, cooler, exp_s);
            miscompares++;
         end
         vectors++;
      end
      sw = 1'b0; sfa = 1'b0; en = 1'b1;
      step();
      exp_s = 2'b01;
      if (hvac_state !== exp_s || heater !== 1'b1) begin
         $display("FAIL inhibit%0d_release: got state=%b heater=%b, want state=%b heater=1",
                  kind, hvac_state, heater, exp_s);
         miscompares++;
      end
      vectors++;
      rst = 1'b1; st = 7'd60; step(); rst = 1'b0;
   endtask

   task automatic test_no_direct_swap();
      logic [1:0] exp_s;
      st = 7'd90;
      for (int i = 0; i < 8; i++) step();
      st = 7'd30;
      for (int i = 0; i < 6; i++) begin
         step();
         exp_s = (i < 4) ? 2'b11 : (i == 4) ? 2'b00 : 2'b01;
         if (hvac_state !== exp_s || heater !== (exp_s == 2'b01) || cooler !== 1'b0) begin
            $display("FAIL no_swap cycle %0d: got state=%b heater=%b cooler=%b, want state=%b",
                     i, hvac_state, heater, cooler, exp_s);
            miscompares++;
         end
         vectors++;
         if (heater === 1'b1 && cooler === 1'b1) begin
            $display("FAIL no_swap_both cycle %0d: got heater=1 cooler=1, want at most one high", i);
            miscompares++;
         end
         vectors++;
      end
      rst = 1'b1; st = 7'd60; step(); rst = 1'b0;
   endtask

   task automatic test_reset_mid_op();
      logic [1:0] exp_s;
      st = 7'd40;
      for (int i = 0; i < 3; i++) step();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         exp_s = 2'b00;
         if (hvac_state !== exp_s || heater !== 1'b0) begin
            $display("FAIL reset_mid cycle %0d: got state=%b heater=%b, want state=%b heater=0",
                     i, hvac_state, heater, exp_s);
            miscompares++;
         end
         vectors++;
      end
      rst = 1'b0;
      step();
      exp_s = 2'b01;
      if (hvac_state !== exp_s || heater !== 1'b1) begin
         $display("FAIL reset_release: got state=%b heater=%b, want state=%b heater=1",
                  hvac_state, heater, exp_s);
         miscompares++;
      end
      vectors++;
      rst = 1'b1; st = 7'd60; step(); rst = 1'b0;
   endtask

   initial begin
      #2;
      test_reset();
      test_heat_min_run();
      test_heat_hysteresis();
      test_cool_hysteresis();
      test_inhibit(0);
      test_inhibit(1);
      test_inhibit(2);
      test_no_direct_swap();
      test_reset_mid_op();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/hvac_controller.md
# hvac_controller

Sequencing controller for the heater and cooler actuators of the home system. Samples the 7-bit temperature sensor each clock, decides when to heat or cool using two thresholds with hysteresis, enforces a minimum run time and a post-run lockout so the actuators never short-cycle or swap directly, and forces both actuators off while the window is open, the fire alarm is active or the block is disabled. Sits between the sensor inputs and the `heater`/`cooler` outputs of the top-level home system.

## Interface
- `LOW_T`, 50: heat demand when `st < LOW_T`.
- `HIGH_T`, 80: cool demand when `st > HIGH_T`.
- `HYST`, 2: hysteresis band applied at the exit thresholds.
- `MIN_ON`, 8: minimum cycles in HEAT or COOL, ≥1.
- `LOCKOUT`, 4: cycles spent in LOCKOUT, ≥1.
- Legal parameter sets require `LOW_T + HYST <= HIGH_T - HYST`, `HIGH_T >= HYST` and `LOW_T + HYST <= 127`.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `st` input 7: unsigned temperature sample.
- `sw` input 1: window open. Acts as an inhibit.
- `sfa` input 1: fire alarm. Acts as an inhibit.
- `en` input 1: controller enable. `en = 0` acts as an inhibit.
- `heater` output 1: registered; high iff the state is HEAT.
- `cooler` output 1: registered; high iff the state is COOL.
- `hvac_state` output 2: current state; IDLE=00, HEAT=01, COOL=10, LOCKOUT=11.

## Operation
- Inhibit is defined as `inh = sw | sfa | ~en`.
- IDLE:
  - `inh` → stay in IDLE.
  - Else `st < LOW_T` → HEAT.
  - Else `st > HIGH_T` → COOL.
  - Else stay in IDLE.
  - Heat is checked first; with legal parameters heat and cool demand cannot both be true.
- HEAT:
  - `inh` → LOCKOUT immediately; this overrides `MIN_ON`.
  - Else `cnt >= MIN_ON-1` and `st >= LOW_T + HYST` → LOCKOUT.
  - Else stay in HEAT.
- COOL:
  - Same as HEAT, except the exit temperature condition is `st <= HIGH_T - HYST`.
- LOCKOUT:
  - `cnt == LOCKOUT-1` → IDLE.
  - Otherwise stay; `inh` is ignored in this state.
  - HEAT↔COOL never happens directly; both paths pass through LOCKOUT and IDLE.
- Counter `cnt`:
  - Cleared on every state change.
  - Increments each cycle spent in HEAT, COOL or LOCKOUT.
  - Saturates at `max(MIN_ON, LOCKOUT)`.
  - Width is `clog2(max(MIN_ON, LOCKOUT) + 1)`.
- Arithmetic: all comparisons are unsigned. `LOW_T + HYST` is computed at 8 bits. `HIGH_T - HYST` cannot underflow under the parameter constraints.
- Reset (`rst` = 1 at an edge):
  - After that edge: state IDLE, `cnt` 0, `heater` 0, `cooler` 0, `hvac_state` 00.
  - No lockout is applied after reset.
  - Reset has priority over every transition, including in mid-HEAT, mid-COOL and mid-LOCKOUT.

## Timing
- Inputs are sampled on the rising edge; outputs change after that same edge, giving one cycle of latency from the sampled condition to the actuator.
- Minimum actuator high time without inhibit is `MIN_ON` cycles.
- Under inhibit the actuator drops at the first edge where `inh` is sampled high.
- LOCKOUT lasts exactly `LOCKOUT` cycles. IDLE then lasts at least 1 cycle.
- The minimum off gap between two actuator activations is therefore `LOCKOUT + 1` cycles.
- Simultaneous events:
  - `inh` together with the exit condition → LOCKOUT; the result is the same either way.
  - `rst` together with anything → IDLE.
- A temperature change during LOCKOUT has no effect until IDLE.

## Test plan
- Heat with minimum run:
  - Stimulus: reset, then `st=40` for one edge, then `st=60`.
  - Required: `heater=1` for exactly 8 cycles, `hvac_state=11` for 4 cycles, then 00 with `heater=0`.
- Heat hysteresis:
  - Stimulus: HEAT held past 8 cycles with `st=51`, then `st=52`.
  - Required: stays 01 at `st=51`; goes to 11 at the first edge sampling `st=52`.
- Cool hysteresis:
  - Stimulus: `st=90`, then after 8 cycles `st=79`, then `st=78`.
  - Required: `cooler=1` from the edge after 90 is sampled; stays on at 79; drops at the edge sampling 78.
- Inhibit:
  - Stimulus: heating 3 cycles, then `sw=1` held, with `st=40`.
  - Required: `heater=0` after the next edge; 4 LOCKOUT cycles; then 00 held while `sw=1`.
  - Required on release: with `sw=0`, HEAT is re-entered one edge later.
  - Repeat with `sfa=1`, and again with `en=0`: required response is identical.
- No direct swap:
  - Stimulus: in COOL after 8 cycles, `st` jumps to 30.
  - Required: `cooler` drops; 4 LOCKOUT cycles; 1 IDLE cycle; then `heater=1`. `heater` and `cooler` are never both 1.
- Reset mid-operation:
  - Stimulus: `rst=1` in HEAT cycle 3 with `st=40` held.
  - Required: state 00 and `heater=0` after the edge; stays IDLE while `rst=1`.
  - Required on release: HEAT one edge after `rst` falls, with no lockout.
